pressure_word_encoder: RTL

Sensor-side encoder for the parity-protected 6-bit pressure word consumed by the pressure abnormality detector. It accepts raw 5-bit pressure samples over a valid/ready handshake and buffers them in a small FIFO. It appends the parity bit and presents each word on a registered valid/ready output, with a programmable minimum idle gap between words. A test hook corrupts the parity of one word on demand, so the downstream abnormality path can be exercised end to end.

---
 rtl/pressure_pkg.sv | 13 +
 rtl/pressure_sample_fifo.sv | 57 +++++
 rtl/pressure_word_encoder.sv | 101 ++++++++++
 3 files changed

// File: rtl/pressure_pkg.sv
// Shared definitions for the parity-protected pressure word.
// The abnormality detector imports the same parity function so both ends agree.
package pressure_pkg;

  localparam int SAMPLE_W   = 5;
  localparam int WORD_W     = 6;
  localparam int PARITY_BIT = 5;

  function automatic logic pressure_parity(input logic [SAMPLE_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/pressure_sample_fifo.sv
// Small circular buffer of raw pressure samples.
// Pointers wrap naturally because DEPTH is a power of two.
// Occupancy is kept as a separate count so full and empty are unambiguous.
module pressure_sample_fifo
  import pressure_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [SAMPLE_W-1:0]          pushData,
  input  logic                         push,
  input  logic                         pop,
  output logic [SAMPLE_W-1:0]          headData,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [SAMPLE_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]    rdPtr;
  logic [PTR_W-1:0]    wrPtr;
  logic                doPush;
  logic                doPop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign doPush   = push && !full;
  assign doPop    = pop && !empty;
  assign headData = mem[rdPtr];

  // Advance pointers and track occupancy; a simultaneous push and pop leaves the count alone.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sample storage needs no reset: a zero count already hides stale entries.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/pressure_word_encoder.sv
// Sensor-side encoder: buffers raw samples, appends parity and presents each
// word on a registered valid/ready output with a programmable idle gap.
// A one-shot test hook flips the parity of the next loaded word.
module pressure_word_encoder
  import pressure_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int GAP        = 0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] sampleData,
  input  logic                sampleValid,
  output logic                sampleReady,
  input  logic                injectError,
  output logic [WORD_W-1:0]   pressureData,
  output logic                pressureValid,
  input  logic                pressureReady,
  output logic [7:0]          wordsSent
);

  localparam int         CNT_W    = $clog2(DEPTH + 1);
  localparam logic [3:0] GAP_LOAD = 4'(GAP);

  logic [SAMPLE_W-1:0] fifoHead;
  logic                fifoFull;
  logic                fifoEmpty;
  logic [CNT_W-1:0]    fifoCount;
  logic                accept;
  logic                handshake;
  logic                gapOpen;
  logic                loadWord;
  logic                corrupt;
  logic [WORD_W-1:0]   nextWord;
  logic [3:0]          gapCnt;
  logic                pendingInject;

  // The counter holds GAP after a handshake and a load is allowed on the edge
  // that ends the last idle cycle, so exactly GAP idle cycles appear on the wire.
  // With GAP = 0 the reload rides on the handshake edge itself.
  assign sampleReady = rst_n && !fifoFull;
  assign accept      = sampleValid && sampleReady;
  assign handshake   = pressureValid && pressureReady;
  assign gapOpen     = handshake ? (GAP == 0) : (gapCnt <= 4'd1);
  assign loadWord    = !fifoEmpty && (!pressureValid || handshake) && gapOpen;
  assign corrupt     = pendingInject || injectError;

  pressure_sample_fifo #(.DEPTH(DEPTH)) sampleFifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .pushData (sampleData),
    .push     (accept),
    .pop      (loadWord),
    .headData (fifoHead),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifoCount)
  );

  // Build the outgoing word from the FIFO head, flipping parity when an injection is due.
  always_comb begin
    nextWord             = {1'b0, fifoHead};
    nextWord[PARITY_BIT] = pressure_parity(fifoHead, PARITY_ODD) ^ corrupt;
  end

  // Output register, gap counter, injection flag and handshake counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pressureData  <= '0;
      pressureValid <= 1'b0;
      wordsSent     <= '0;
      gapCnt        <= '0;
      pendingInject <= 1'b0;
    end else begin
      if (handshake) wordsSent <= wordsSent + 1'b1;

      if (handshake)          gapCnt <= GAP_LOAD;
      else if (gapCnt != '0)  gapCnt <= gapCnt - 1'b1;

      if (loadWord) begin
        pressureData  <= nextWord;
        pressureValid <= 1'b1;
      end else if (handshake) begin
        pressureValid <= 1'b0;
      end

      if (loadWord)         pendingInject <= 1'b0;
      else if (injectError) pendingInject <= 1'b1;
    end
  end

  // Occupancy flags and the count must always tell the same story.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (fifoFull == (fifoCount == CNT_W'(DEPTH)));
      assert (fifoEmpty == (fifoCount == '0));
    end
  end

endmodule
